// File: rtl/multicycle_controller_if.sv
// Control bundle between the RV32I multi-cycle controller and its datapath.
// master: the controller (drives control lines), slave: the datapath.
// Optional macro CTRL_PERF_COUNTERS_EN adds the instret/br_taken counters.
interface multicycle_controller_if #(
  parameter int DWIDTH = 32,
  parameter int ST_W   = 3
);
  logic [DWIDTH-1:0] irOut;
  logic              comparatorOut;
  logic              pcEn;
  logic [1:0]        pcSelect;
  logic              regWrite;
  logic              aluSrc;
  logic              ramRdEn;
  logic              ramWrEn;
  logic              isByte;
  logic              isHalf;
  logic              isWord;
  logic [1:0]        memToReg;
  logic              halted;
  logic              illegal;
  logic [ST_W-1:0]   state_dbg;
`ifdef CTRL_PERF_COUNTERS_EN
  logic [31:0]       instret;
  logic [31:0]       br_taken;
`endif

  modport master (
`ifdef CTRL_PERF_COUNTERS_EN
    output instret, br_taken,
`endif
    input  irOut, comparatorOut,
    output pcEn, pcSelect, regWrite, aluSrc, ramRdEn, ramWrEn,
    output isByte, isHalf, isWord, memToReg, halted, illegal, state_dbg
  );

  modport slave (
`ifdef CTRL_PERF_COUNTERS_EN
    input  instret, br_taken,
`endif
    output irOut, comparatorOut,
    input  pcEn, pcSelect, regWrite, aluSrc, ramRdEn, ramWrEn,
    input  isByte, isHalf, isWord, memToReg, halted, illegal, state_dbg
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB plus absorbing
// HALT and TRAP. Outputs decode from the state register and irOut only.
// Optional macro CTRL_PERF_COUNTERS_EN adds instret/br_taken counters.
module multicycle_controller #(
  parameter int DWIDTH = 32,
  parameter int ST_W   = 3
) (
  input logic                     clk,
  input logic                     reset,
  multicycle_controller_if.master bus
);
  typedef enum logic [ST_W-1:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5,
    StTrap   = 3'd6
  } state_e;

  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpSystem = 7'b1110011;

  state_e stateQ, stateD;

  logic [DWIDTH-1:0] ir;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              isLoad, isStore, immSrc, memOk;
  logic              wByte, wHalf, wWord;
  logic              unusedIr;

  assign ir       = bus.irOut;
  assign opcode   = ir[6:0];
  assign funct3   = ir[14:12];
  assign unusedIr = ^{ir[DWIDTH-1:15], ir[11:7]};

  assign isLoad  = (opcode == OpLoad);
  assign isStore = (opcode == OpStore);
  assign immSrc  = (opcode == OpOpImm) || isLoad || isStore || (opcode == OpJalr);
  assign wByte   = (funct3 == 3'b000) || (funct3 == 3'b100);
  assign wHalf   = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign wWord   = (funct3 == 3'b010);
  // Stores only support the signed encodings; loads also allow LBU/LHU.
  assign memOk   = isStore ? (funct3 <= 3'b010) : (wByte || wHalf || wWord);

  logic       pcEnC, regWriteC, aluSrcC, ramRdEnC, ramWrEnC;
  logic       isByteC, isHalfC, isWordC, haltedC, illegalC;
  logic [1:0] pcSelectC, memToRegC;

  // State register; reset abandons any in-flight instruction.
  always_ff @(posedge clk) begin
    if (reset) stateQ <= StFetch;
    else       stateQ <= stateD;
  end

  // Next-state and control decode.
  always_comb begin
    stateD    = stateQ;
    pcEnC     = 1'b0;
    pcSelectC = 2'b00;
    regWriteC = 1'b0;
    aluSrcC   = 1'b0;
    ramRdEnC  = 1'b0;
    ramWrEnC  = 1'b0;
    isByteC   = 1'b0;
    isHalfC   = 1'b0;
    isWordC   = 1'b0;
    memToRegC = 2'b00;
    haltedC   = 1'b0;
    illegalC  = 1'b0;
    unique case (stateQ)
      StFetch:  stateD = StDecode;
      StDecode: begin
        case (opcode)
          OpOp, OpOpImm, OpLui, OpJal, OpJalr, OpLoad, OpStore, OpBranch: stateD = StExec;
          OpSystem: stateD = StHalt;
          default:  stateD = StTrap;
        endcase
      end
      StExec: begin
        aluSrcC = immSrc;
        if (opcode == OpBranch) begin
          pcEnC     = 1'b1;
          pcSelectC = 2'b01;
          stateD    = StFetch;
        end else if (isLoad || isStore) begin
          stateD = StMem;
        end else begin
          stateD = StWb;
        end
      end
      StMem: begin
        aluSrcC = 1'b1;
        if (!memOk || !(isLoad || isStore)) begin
          stateD = StTrap;
        end else begin
          isByteC = wByte;
          isHalfC = wHalf;
          isWordC = wWord;
          if (isLoad) begin
            ramRdEnC = 1'b1;
            stateD   = StWb;
          end else begin
            ramWrEnC = 1'b1;
            pcEnC    = 1'b1;
            stateD   = StFetch;
          end
        end
      end
      StWb: begin
        regWriteC = 1'b1;
        pcEnC     = 1'b1;
        aluSrcC   = immSrc;
        stateD    = StFetch;
        case (opcode)
          OpLoad: begin
            memToRegC = 2'b01;
            ramRdEnC  = 1'b1;
            isByteC   = wByte;
            isHalfC   = wHalf;
            isWordC   = wWord;
          end
          OpJal: begin
            memToRegC = 2'b10;
            pcSelectC = 2'b11;
          end
          OpJalr: begin
            memToRegC = 2'b10;
            pcSelectC = 2'b10;
          end
          OpLui:   memToRegC = 2'b11;
          default: memToRegC = 2'b00;
        endcase
      end
      StHalt:  haltedC  = 1'b1;
      StTrap:  illegalC = 1'b1;
      default: stateD   = StTrap;
    endcase
  end

  // Outputs are forced low while reset is sampled so nothing retires.
  assign bus.pcEn      = ~reset & pcEnC;
  assign bus.pcSelect  = reset ? 2'b00 : pcSelectC;
  assign bus.regWrite  = ~reset & regWriteC;
  assign bus.aluSrc    = ~reset & aluSrcC;
  assign bus.ramRdEn   = ~reset & ramRdEnC;
  assign bus.ramWrEn   = ~reset & ramWrEnC;
  assign bus.isByte    = ~reset & isByteC;
  assign bus.isHalf    = ~reset & isHalfC;
  assign bus.isWord    = ~reset & isWordC;
  assign bus.memToReg  = reset ? 2'b00 : memToRegC;
  assign bus.halted    = ~reset & haltedC;
  assign bus.illegal   = ~reset & illegalC;
  assign bus.state_dbg = reset ? '0 : stateQ;

`ifdef CTRL_PERF_COUNTERS_EN
  logic [31:0] instretQ, brTakenQ;

  // Retired-instruction and taken-branch counters, free-running with wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      instretQ <= '0;
      brTakenQ <= '0;
    end else begin
      if (pcEnC) instretQ <= instretQ + 32'd1;
      if (pcEnC && (pcSelectC == 2'b01) && bus.comparatorOut) brTakenQ <= brTakenQ + 32'd1;
    end
  end

  assign bus.instret  = instretQ;
  assign bus.br_taken = brTakenQ;
`else
  logic unusedCmp;
  assign unusedCmp = bus.comparatorOut;
`endif
endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed programme steps
// followed by random instruction streams checked against an instruction-level
// reference model (state schedule, retirement counts, selects, widths).
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_controller_if #(.DWIDTH(32), .ST_W(3)) bus ();
  multicycle_controller #(.DWIDTH(32), .ST_W(3)) dut (.clk(clk), .reset(reset), .bus(bus));

  int vectors = 0;
  int miscompares = 0;
  int unsigned mInstret = 0;
  int unsigned mBrTaken = 0;

  localparam logic [6:0] OP = 7'b0110011, OPIMM = 7'b0010011, LUI = 7'b0110111;
  localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111, LOAD = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011, BRANCH = 7'b1100011, SYSTEM = 7'b1110011;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] allOuts();
    return {bus.pcEn, bus.pcSelect, bus.regWrite, bus.aluSrc, bus.ramRdEn, bus.ramWrEn,
            bus.isByte, bus.isHalf, bus.isWord, bus.memToReg, bus.halted, bus.illegal,
            bus.state_dbg};
  endfunction

  task automatic checkPerf(input string tag);
`ifdef CTRL_PERF_COUNTERS_EN
    chk({tag, "_instret"}, bus.instret, mInstret);
    chk({tag, "_br_taken"}, bus.br_taken, mBrTaken);
`else
    if (tag.len() == 0) $display("empty tag");
`endif
  endtask

  task automatic doReset(input int n);
    reset = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
      chk("outs_in_reset", 32'(allOuts()), 32'd0);
    end
    mInstret = 0;
    mBrTaken = 0;
    reset = 1'b0;
    #1;
    chk("outs_after_reset", 32'(allOuts()), 32'd0);
    checkPerf("after_reset");
  endtask

  function automatic bit isKnown(input logic [6:0] op);
    return op inside {OP, OPIMM, LUI, JAL, JALR, LOAD, STORE, BRANCH, SYSTEM};
  endfunction

  // Per-cycle checks valid in any state.
  task automatic checkCycle(input int expSt);
    chk("state", 32'(bus.state_dbg), 32'(expSt));
    chk("halted", 32'(bus.halted), 32'(expSt == 5));
    chk("illegal", 32'(bus.illegal), 32'(expSt == 6));
    chk("wr_exclusive", 32'(bus.regWrite & bus.ramWrEn), 32'd0);
    chk("strobe_onehot", $countones({bus.isByte, bus.isHalf, bus.isWord}),
        32'(bus.ramRdEn | bus.ramWrEn));
  endtask

  // Run one instruction from FETCH; cmp < 0 randomises comparatorOut per cycle.
  task automatic runInstr(input logic [31:0] ins, input int cmp, output bit term);
    logic [6:0] op;
    logic [2:0] f3;
    bit ld, st, memOk, retire, writes;
    int sts[$];
    int nPc, pcAt, nWr, nRd, nRamWr, nAlu, expAlu;
    logic [1:0] selSeen, m2rSeen, expSel, expM2r;
    logic [2:0] widthSeen, expWidth;
    bit cmpExec;
    op = ins[6:0];
    f3 = ins[14:12];
    ld = (op == LOAD);
    st = (op == STORE);
    memOk = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    sts = '{0, 1};
    term = 1'b0;
    if (op == SYSTEM) begin sts.push_back(5); term = 1'b1; end
    else if (!isKnown(op)) begin sts.push_back(6); term = 1'b1; end
    else begin
      sts.push_back(2);
      if (ld || st) begin
        sts.push_back(3);
        if (!memOk) begin sts.push_back(6); term = 1'b1; end
        else if (ld) sts.push_back(4);
      end else if (op != BRANCH) sts.push_back(4);
    end
    retire = !term;
    writes = retire && (op inside {OP, OPIMM, LUI, JAL, JALR, LOAD});
    expSel = (op == BRANCH) ? 2'b01 : (op == JAL) ? 2'b11 : (op == JALR) ? 2'b10 : 2'b00;
    expM2r = ld ? 2'b01 : (op inside {JAL, JALR}) ? 2'b10 : (op == LUI) ? 2'b11 : 2'b00;
    expWidth = 3'b000;
    if ((ld || st) && memOk)
      expWidth = (f3 inside {3'd0, 3'd4}) ? 3'b001 : (f3 inside {3'd1, 3'd5}) ? 3'b010 : 3'b100;
    if (op inside {OPIMM, JALR}) expAlu = 2;
    else if (ld && memOk) expAlu = 3;
    else if (ld || st) expAlu = 2;
    else expAlu = 0;
    nPc = 0; pcAt = -1; nWr = 0; nRd = 0; nRamWr = 0; nAlu = 0;
    selSeen = 2'b00; m2rSeen = 2'b00; widthSeen = 3'b000; cmpExec = 1'b0;
    for (int i = 0; i < sts.size(); i++) begin
      bus.irOut = ins;
      bus.comparatorOut = (cmp < 0) ? 1'($urandom_range(1)) : 1'(cmp);
      #1;
      checkCycle(sts[i]);
      if (i == 2) cmpExec = bus.comparatorOut;
      if (bus.pcEn) begin nPc++; pcAt = i; selSeen = bus.pcSelect; end
      if (bus.regWrite) begin nWr++; m2rSeen = bus.memToReg; end
      nRd += int'(bus.ramRdEn);
      nRamWr += int'(bus.ramWrEn);
      nAlu += int'(bus.aluSrc);
      widthSeen |= {bus.isWord, bus.isHalf, bus.isByte};
      @(posedge clk); #1;
    end
    chk("pcEn_count", nPc, 32'(retire));
    if (retire) begin
      chk("pcEn_last_cycle", pcAt, sts.size() - 1);
      chk("pcSelect", 32'(selSeen), 32'(expSel));
    end
    chk("regWrite_count", nWr, 32'(writes));
    if (writes) chk("memToReg", 32'(m2rSeen), 32'(expM2r));
    chk("ramRd_cycles", nRd, (ld && memOk) ? 2 : 0);
    chk("ramWr_count", nRamWr, 32'(st && memOk));
    chk("width", 32'(widthSeen), 32'(expWidth));
    chk("aluSrc_cycles", nAlu, expAlu);
    if (retire) begin
      mInstret++;
      if (op == BRANCH && cmpExec) mBrTaken++;
      checkPerf("retire");
    end else begin
      repeat (10) begin
        #1;
        checkCycle(sts[sts.size() - 1]);
        chk("absorbing_enables", 32'({bus.pcEn, bus.regWrite, bus.ramRdEn, bus.ramWrEn}), 0);
        @(posedge clk);
      end
      #1;
    end
  endtask

  function automatic logic [31:0] genInstr();
    logic [6:0] legal [8];
    logic [31:0] ins;
    int r;
    legal = '{OP, OPIMM, LUI, JAL, JALR, LOAD, STORE, BRANCH};
    ins = $urandom;
    r = $urandom_range(99);
    if (r < 4) ins[6:0] = SYSTEM;
    else if (r < 8) begin
      do ins[6:0] = 7'($urandom); while (isKnown(ins[6:0]));
    end else ins[6:0] = legal[$urandom_range(7)];
    return ins;
  endfunction

  initial begin
    bit term;
    reset = 1'b1;
    bus.irOut = '0;
    bus.comparatorOut = 1'b0;
    doReset(2);
    runInstr(32'h0000_0013, -1, term);  // ADDI
    runInstr(32'h0002_A303, -1, term);  // LW
    runInstr(32'h0062_8023, -1, term);  // SB
    doReset(2);
    runInstr(32'h0062_8463, 1, term);   // BEQ taken
    runInstr(32'h0062_8463, 0, term);   // BEQ not taken
    runInstr(32'h0080_00EF, -1, term);  // JAL
    runInstr(32'h0000_0073, -1, term);  // ECALL
    chk("ecall_terminal", 32'(term), 32'd1);
    doReset(2);
    runInstr(32'h0000_007F, -1, term);  // undecodable opcode
    chk("trap_terminal", 32'(term), 32'd1);
    doReset(1);
    // LW abandoned by reset in MEM.
    bus.irOut = 32'h0002_A303;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkCycle(i);
      if (i < 3) begin @(posedge clk); #1; end
    end
    chk("mem_ramRdEn", 32'(bus.ramRdEn), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_enables", 32'({bus.pcEn, bus.regWrite, bus.ramRdEn, bus.ramWrEn}), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    mInstret = 0;
    mBrTaken = 0;
    #1;
    chk("abort_outs", 32'(allOuts()), 32'd0);
    checkPerf("abort");
    runInstr(32'h0002_A303, -1, term);
    for (int seg = 0; seg < 8; seg++) begin
      doReset(1 + $urandom_range(1));
      for (int k = 0; k < 30; k++) begin
        runInstr(genInstr(), -1, term);
        if (term) break;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle control FSM driving every control input of the RV32I datapath: PC enable/select, register-file write, ALU source, RAM enables/width and writeback mux select.
- Consumes the datapath's instruction-register output and branch-comparator output.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB so that exactly one architectural update occurs per instruction.

Parameters:
- DWIDTH, 32, width of the instruction input.
- ST_W, 3, width of the state register and of the state_dbg port.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- irOut  in  DWIDTH  current instruction from the instruction register.
- comparatorOut  in  1  branch condition from the datapath comparator.
- pcEn  out  1  PC update enable (one-cycle pulse per instruction).
- pcSelect  out  2  00 = PC+4, 01 = conditional branch PC+imm, 10 = ALU result (JALR), 11 = PC+imm (JAL).
- regWrite  out  1  register-file write enable.
- aluSrc  out  1  0 = rs2, 1 = immediate.
- ramRdEn  out  1  RAM read enable.
- ramWrEn  out  1  RAM write enable.
- isByte, isHalf, isWord  out  1 each  access width, one-hot during a RAM access, otherwise 0.
- memToReg  out  2  00 = ALU, 01 = RAM, 10 = PC link value, 11 = immediate.
- halted  out  1  sticky; set on ECALL/EBREAK.
- illegal  out  1  sticky; set on an undecodable opcode or funct3.
- state_dbg  out  ST_W  current state encoding.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is clk, reset port is reset.
- Reset: state = FETCH, halted = 0, illegal = 0. All outputs are 0 during and in the cycle after reset.
- Reset mid-instruction abandons the instruction. No pcEn, regWrite or ramWrEn is issued after reset is sampled.
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, TRAP=6.
- Outputs are a combinational function of the state register and irOut opcode/funct3 only. There is no combinational path from comparatorOut to any output.
- irOut is stable from DECODE until the pcEn cycle, because the PC does not change before that cycle.
- FETCH -> DECODE unconditionally; this is the instruction-memory read latency slot. All outputs 0.
- DECODE: classify irOut[6:0].
  - OP 0110011 / OP-IMM 0010011 / LUI 0110111 / JAL 1101111 / JALR 1100111 / LOAD 0000011 / STORE 0100011 / BRANCH 1100011 -> EXEC.
  - SYSTEM 1110011 -> HALT.
  - Anything else -> TRAP.
- EXEC:
  - aluSrc = 1 for OP-IMM, LOAD, STORE and JALR.
  - BRANCH: pcEn = 1, pcSelect = 01 -> FETCH. The PC controller resolves comparatorOut.
  - LOAD/STORE -> MEM. All other classes -> WB.
- MEM: aluSrc = 1 and width strobes are driven from funct3.
  - funct3 000/100 -> isByte; 001/101 -> isHalf; 010 -> isWord.
  - LOAD: ramRdEn = 1 -> WB.
  - STORE: ramWrEn = 1, pcEn = 1, pcSelect = 00 -> FETCH. STORE funct3 > 010 -> TRAP, with no ramWrEn.
  - LOAD funct3 011/110/111 -> TRAP, with no ramRdEn.
- WB: regWrite = 1 and pcEn = 1 in the same cycle -> FETCH.
  - memToReg: OP/OP-IMM 00, LOAD 01, JAL/JALR 10, LUI 11.
  - pcSelect: 11 for JAL, 10 for JALR, else 00.
  - The link value uses the pre-update PC, because the register write and the PC update share one edge.
  - LOAD keeps ramRdEn = 1, the width strobes and aluSrc = 1 held through WB.
- Latency: BRANCH 3 cycles; OP/OP-IMM/LUI/JAL/JALR/STORE 4 cycles; LOAD 5 cycles.
- HALT and TRAP are absorbing until reset. All enables are 0 there. halted (HALT) or illegal (TRAP) is asserted from the first cycle in that state.
- Exactly one pcEn pulse per retired instruction. regWrite and ramWrEn are never both high.

Optional Feature:
- Macro CTRL_PERF_COUNTERS_EN.
- When defined, adds outputs instret (32-bit) and br_taken (32-bit), both cleared on reset.
  - instret increments on every pcEn cycle.
  - br_taken increments on a BRANCH pcEn cycle when comparatorOut = 1.
  - Both wrap from 0xFFFFFFFF to 0.
- When undefined, these ports do not exist and comparatorOut is unused.

Test Plan:
- Reset 2 cycles, then irOut=0x00000013 (ADDI x0,x0,0) -> states 0,1,2,4,0. pcEn=1 only in WB, aluSrc=1, regWrite=1, memToReg=00.
- LW irOut=0x0002A303 -> states 0,1,2,3,4. ramRdEn=1 in MEM and WB, isWord=1, memToReg=01 in WB; 5 cycles total.
- SB irOut=0x00628023 -> in MEM: ramWrEn=1, isByte=1, pcEn=1, regWrite=0; back to FETCH after 4 cycles.
- BEQ irOut=0x00628463 with comparatorOut held 1, then repeated with it held 0 -> pcEn=1, pcSelect=01 in EXEC both times. With the macro defined, br_taken=1 and instret=2.
- JAL irOut=0x008000EF -> in WB: regWrite=1, memToReg=10, pcSelect=11, pcEn=1. Then irOut=0x00000073 (ECALL) -> HALT; halted=1, no further pcEn for 10 cycles.
- Opcode 0x0000007F -> TRAP, illegal=1. Then reset asserted for 1 cycle mid-LW (MEM state) -> FETCH with illegal=0, no ramRdEn or regWrite issued.
